sha256_core: RTL and testbench
==============================

Name: sha256_core

Overview:
- Single-block SHA-256 compression engine: takes one pre-padded 512-bit message block, runs 64 rounds and outputs the 256-bit digest.
- Software or an upstream padder supplies padding and length; this block does no padding.
- Iterative: one round per clock, start/done handshake, used as a hash leaf in the crypto subsystem.

Parameters:
- None. Round count (64), K constants and IV are fixed by FIPS 180-4.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- i_Data  input  512  padded message block; bits [511:480] = W0 (big-endian words).
- o_Data  output  256  digest; [255:224] = H0 … [31:0] = H7.
- i_fStart  input  1  start pulse, sampled on rising Clk.
- o_fDone  output  1  one-cycle pulse when o_Data becomes valid.

Behaviour:
- Reset (Rst=0, async): FSM to IDLE, o_Data=0, o_fDone=0, round counter=0, working regs a..h=0. Reset mid-operation aborts with no done pulse.
- FSM states:
  - IDLE
  - ROUND: 64 cycles, counter t=0..63
  - FINAL: 1 cycle
  - back to IDLE
- IDLE, i_fStart=1 at edge N:
  - latch i_Data into a 16×32 schedule window.
  - load a..h with IV 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
  - t=0; go to ROUND.
- ROUND, edges N+1..N+64: one compression round per edge.
  - W_t taken from the window head.
  - Window shifts with new W = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - T1 = h + Σ1(e) + Ch(e,f,g) + K_t + W_t; T2 = Σ0(a) + Maj(a,b,c).
  - All additions mod 2^32.
- FINAL, edge N+65: o_Data ← {IV_i + working_i} mod 2^32 per word; o_fDone=1 for exactly that cycle; return to IDLE.
- Latency: done visible 65 cycles after the start edge.
- o_Data holds the last digest until the next FINAL or reset; it is not cleared at start.
- i_fStart while in ROUND/FINAL: ignored, no queuing.
- i_Data is only sampled at the start edge; later changes have no effect.
- i_fStart held high: a new hash starts in the IDLE cycle after FINAL. Back-to-back throughput is one block per 66 cycles.

Optional Feature:
- Macro SHA_CHAIN_EN enables multi-block chaining.
- Defined:
  - Extra input port i_fFirst (1 bit), sampled with i_fStart.
  - i_fFirst=1: initial hash = IV.
  - i_fFirst=0: initial hash = the current o_Data, i.e. the previous digest.
  - FINAL adds that initial hash.
- Undefined: no i_fFirst port; IV is used on every start.

Decomposition:
- Package sha256_pkg holds:
  - 64-entry K constant array and 8-word IV constant.
  - Σ0/Σ1/σ0/σ1/Ch/Maj as functions.
  - Round-count localparam and the FSM state enum.
- One natural sub-module: sha256_msg_sched. It holds the 16-word shift window, loads on start, shifts each round, and outputs W_t.

Test Plan:
- "abc" block 61626380_0…0_00000018, Rst released, start pulse → o_fDone 65 cycles later with o_Data = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty-message block 80000000_0…0_00000000 → o_Data = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, o_fDone exactly one cycle.
- Reset during round 30 → o_Data=0, o_fDone never pulses; a following "abc" start gives the correct digest.
- Start pulse at round 10 with a different i_Data → ignored; "abc" digest is still produced at the original time.
- i_fStart held high for two blocks (abc, then empty) → two done pulses 66 cycles apart with both correct digests.
- SHA_CHAIN_EN, two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 with i_fFirst=1.
  - block 2 (zeros, length 000001c0) with i_fFirst=0.
  - → o_Data = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions and FSM state type.
// Used by sha256_core (chaining via SHA_CHAIN_EN) and sha256_msg_sched.
package sha256_pkg;

  localparam int SHA_ROUNDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } sha_state_e;

  localparam logic [0:7][31:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA_K [SHA_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word SHA-256 message schedule window; head word (index 15) is W_t.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [511:0] block_i,
  output logic [31:0]  w_o
);

  // win_q[15 - j] holds W[t + j], so loading the block places W0 at the head.
  logic [15:0][31:0] win_q, win_d;
  logic [31:0]       w_new;

  assign w_new = small_sigma1(win_q[1]) + win_q[6] + small_sigma0(win_q[14]) + win_q[15];
  assign w_o   = win_q[15];

  always_comb begin
    win_d = win_q;
    if (load_i) begin
      win_d = block_i;
    end else if (shift_i) begin
      win_d = {win_q[14:0], w_new};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

endmodule

// File: rtl/sha256_core.sv
// Iterative single-block SHA-256 compression, one round per clock.
// Define SHA_CHAIN_EN to add i_fFirst for multi-block chaining from the previous digest.
module sha256_core
  import sha256_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst,
  input  logic [511:0] i_Data,
  input  logic         i_fStart,
`ifdef SHA_CHAIN_EN
  input  logic         i_fFirst,
`endif
  output logic [255:0] o_Data,
  output logic         o_fDone
);

  sha_state_e       state_q, state_d;
  logic [5:0]       round_q, round_d;
  logic [0:7][31:0] work_q, work_d;
  logic [0:7][31:0] digest_q, digest_d;
  logic             done_q, done_d;
  logic [0:7][31:0] init_hash;
  logic [0:7][31:0] hinit;
  logic [31:0]      w_t, t1, t2;
  logic             sched_load, sched_shift;

  localparam logic [5:0] ROUND_LAST = 6'(SHA_ROUNDS - 1);

`ifdef SHA_CHAIN_EN
  // Initial hash is captured at start because o_Data is overwritten by FINAL.
  logic [0:7][31:0] hinit_q;
  assign init_hash = i_fFirst ? SHA_IV : digest_q;
  assign hinit     = hinit_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hinit_q <= '0;
    end else if (sched_load) begin
      hinit_q <= init_hash;
    end
  end
`else
  assign init_hash = SHA_IV;
  assign hinit     = SHA_IV;
`endif

  sha256_msg_sched u_sched (
    .clk_i   (Clk),
    .rst_ni  (Rst),
    .load_i  (sched_load),
    .shift_i (sched_shift),
    .block_i (i_Data),
    .w_o     (w_t)
  );

  assign t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
            + SHA_K[round_q] + w_t;
  assign t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    work_d      = work_q;
    digest_d    = digest_q;
    done_d      = 1'b0;
    sched_load  = 1'b0;
    sched_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_fStart) begin
          sched_load = 1'b1;
          work_d     = init_hash;
          round_d    = '0;
          state_d    = ST_ROUND;
        end
      end
      ST_ROUND: begin
        sched_shift = 1'b1;
        work_d = {t1 + t2, work_q[0], work_q[1], work_q[2],
                  work_q[3] + t1, work_q[4], work_q[5], work_q[6]};
        if (round_q == ROUND_LAST) begin
          round_d = '0;
          state_d = ST_FINAL;
        end else begin
          round_d = round_q + 6'd1;
        end
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          digest_d[i] = work_q[i] + hinit[i];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      work_q   <= '0;
      digest_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      work_q   <= work_d;
      digest_q <= digest_d;
      done_q   <= done_d;
    end
  end

  assign o_Data  = digest_q;
  assign o_fDone = done_q;

endmodule

// File: tb/tb_sha256_core.sv
// Directed-vector bench for sha256_core with a digest scoreboard fed at each start.
module tb_sha256_core;

  logic         Clk;
  logic         Rst;
  logic [511:0] i_Data;
  logic         i_fStart;
  logic         first_r;
  logic [255:0] o_Data;
  logic         o_fDone;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_CH1   = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_CH2   = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_CHAIN = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;
  int prev_done_cyc;
  int base_cnt;

  logic [255:0] exp_q[$];
  bit           chk_q[$];

  sha256_core dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_Data   (i_Data),
    .i_fStart (i_fStart),
`ifdef SHA_CHAIN_EN
    .i_fFirst (first_r),
`endif
    .o_Data   (o_Data),
    .o_fDone  (o_fDone)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every done pulse consumes one expected digest
  always @(negedge Clk) begin
    if (Rst && o_fDone) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_done", {255'h0, o_fDone}, 256'h0);
      end else begin
        logic [255:0] e;
        bit c;
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        if (c) check("digest", o_Data, e);
      end
    end
  end

  // drivers
  task automatic start_block(input logic [511:0] data, input logic first,
                             input logic [255:0] exp, input bit chk);
    @(negedge Clk);
    i_Data   = data;
    first_r  = first;
    i_fStart = 1'b1;
    exp_q.push_back(exp);
    chk_q.push_back(chk);
    @(posedge Clk);
    #1 start_cyc = cyc;
    @(negedge Clk);
    i_fStart = 1'b0;
    for (int i = 0; i < 16; i++) i_Data[32*i +: 32] = $urandom();
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge Clk);
      #1 n++;
    end
    check("done_seen", 256'(done_cnt), 256'(target));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Rst      = 1'b0;
    i_Data   = '0;
    i_fStart = 1'b0;
    first_r  = 1'b1;

    // reset state
    idle_cycles(3);
    check("reset_data", o_Data, 256'h0);
    check("reset_done", {255'h0, o_fDone}, 256'h0);
    Rst = 1'b1;
    idle_cycles(2);

    // "abc": latency and single-cycle done
    start_block(BLK_ABC, 1'b1, DIG_ABC, 1'b1);
    wait_done(1, 100);
    check("abc_latency", 256'(last_done_cyc - start_cyc), 256'd65);
    @(negedge Clk);
    check("abc_done_width", {255'h0, o_fDone}, 256'h0);

    // empty message; o_Data keeps the old digest while the new hash runs
    idle_cycles(4);
    check("hold_idle", o_Data, DIG_ABC);
    start_block(BLK_EMPTY, 1'b1, DIG_EMPTY, 1'b1);
    idle_cycles(20);
    check("hold_during_round", o_Data, DIG_ABC);
    wait_done(2, 100);
    check("empty_latency", 256'(last_done_cyc - start_cyc), 256'd65);
    @(negedge Clk);
    check("empty_done_width", {255'h0, o_fDone}, 256'h0);

    // reset during round 30 aborts with no done
    start_block(BLK_ABC, 1'b1, DIG_ABC, 1'b1);
    idle_cycles(30);
    Rst = 1'b0;
    exp_q.delete();
    chk_q.delete();
    #1 check("abort_data", o_Data, 256'h0);
    check("abort_done", {255'h0, o_fDone}, 256'h0);
    idle_cycles(3);
    Rst = 1'b1;
    base_cnt = done_cnt;
    idle_cycles(80);
    check("abort_no_done", 256'(done_cnt), 256'(base_cnt));
    start_block(BLK_ABC, 1'b1, DIG_ABC, 1'b1);
    wait_done(base_cnt + 1, 100);
    check("after_abort_latency", 256'(last_done_cyc - start_cyc), 256'd65);

    // start during round 10 is ignored
    idle_cycles(3);
    base_cnt = done_cnt;
    start_block(BLK_ABC, 1'b1, DIG_ABC, 1'b1);
    idle_cycles(10);
    i_Data   = BLK_EMPTY;
    i_fStart = 1'b1;
    @(negedge Clk);
    i_fStart = 1'b0;
    wait_done(base_cnt + 1, 100);
    check("ignored_start_latency", 256'(last_done_cyc - start_cyc), 256'd65);
    idle_cycles(80);
    check("ignored_start_one_done", 256'(done_cnt), 256'(base_cnt + 1));

    // start held high: abc then empty, back to back
    base_cnt = done_cnt;
    @(negedge Clk);
    i_Data   = BLK_ABC;
    i_fStart = 1'b1;
    exp_q.push_back(DIG_ABC);
    chk_q.push_back(1'b1);
    exp_q.push_back(DIG_EMPTY);
    chk_q.push_back(1'b1);
    @(posedge Clk);
    #1 start_cyc = cyc;
    @(negedge Clk);
    i_Data = BLK_EMPTY;
    wait_done(base_cnt + 1, 100);
    check("b2b_first_latency", 256'(last_done_cyc - start_cyc), 256'd65);
    prev_done_cyc = last_done_cyc;
    @(posedge Clk);
    @(negedge Clk);
    i_fStart = 1'b0;
    for (int i = 0; i < 16; i++) i_Data[32*i +: 32] = $urandom();
    wait_done(base_cnt + 2, 100);
    check("b2b_spacing", 256'(last_done_cyc - prev_done_cyc), 256'd66);
    idle_cycles(70);
    check("b2b_no_third", 256'(done_cnt), 256'(base_cnt + 2));

`ifdef SHA_CHAIN_EN
    // two-block message chained through the previous digest
    base_cnt = done_cnt;
    start_block(BLK_CH1, 1'b1, 256'h0, 1'b0);
    wait_done(base_cnt + 1, 100);
    start_block(BLK_CH2, 1'b0, DIG_CHAIN, 1'b1);
    wait_done(base_cnt + 2, 100);
    check("chain_final", o_Data, DIG_CHAIN);
    start_block(BLK_ABC, 1'b1, DIG_ABC, 1'b1);
    wait_done(base_cnt + 3, 100);
    check("chain_restart_iv", o_Data, DIG_ABC);
`endif

    check("scoreboard_empty", 256'(exp_q.size()), 256'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
